action_selector: RTL and testbench

Epsilon-greedy policy and episode controller for the 5x5 grid-world Q-learning datapath. It sits directly upstream of the grid position checker. Each step it takes the four Q-values of the current state, picks an action (random explore or greedy argmax), and drives `act`. It also counts steps and episodes, pulses `change_iteration` to restart the agent at state 1 when an episode ends, and decays epsilon between episodes.

---
 rtl/action_selector.sv | 145 ++++++++++++++
 tb/tb_action_selector.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/action_selector.sv
// Epsilon-greedy action selection and episode control
// for the 5x5 grid-world Q-learning datapath.
module action_selector #(
    parameter int unsigned Q_WIDTH      = 16,
    parameter int unsigned GOAL_STATE   = 25,
    parameter int unsigned MAX_STEPS    = 32,
    parameter int unsigned MAX_EPISODES = 100,
    parameter logic [7:0]  EPS_INIT     = 8'd230,
    parameter logic [7:0]  EPS_DECAY    = 8'd2,
    parameter logic [7:0]  EPS_MIN      = 8'd13
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [4:0]                state_in,
    input  logic signed [Q_WIDTH-1:0] q0,
    input  logic signed [Q_WIDTH-1:0] q1,
    input  logic signed [Q_WIDTH-1:0] q2,
    input  logic signed [Q_WIDTH-1:0] q3,
    input  logic                      q_valid,
    output logic                      q_req,
    output logic [1:0]                act,
    output logic                      act_valid,
    output logic                      change_iteration,
    output logic [7:0]                step_cnt,
    output logic [7:0]                episode_cnt,
    output logic [7:0]                epsilon,
    output logic                      done
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_REQ      = 3'd1;
    localparam logic [2:0] S_SELECT   = 3'd2;
    localparam logic [2:0] S_SETTLE   = 3'd3;
    localparam logic [2:0] S_CHECK    = 3'd4;
    localparam logic [2:0] S_END      = 3'd5;
    localparam logic [2:0] S_SETTLE_R = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    localparam logic [4:0]  GOAL  = 5'(GOAL_STATE);
    localparam logic [7:0]  MAX_S = 8'(MAX_STEPS);
    localparam logic [7:0]  MAX_E = 8'(MAX_EPISODES);
    localparam logic [15:0] SEED  = 16'hACE1;

    logic [2:0]  state;
    logic [2:0]  state_nx;
    logic [15:0] lfsr;
    logic [15:0] lfsr_nx;

    logic [1:0]                idx01;
    logic [1:0]                idx23;
    logic signed [Q_WIDTH-1:0] val01;
    logic signed [Q_WIDTH-1:0] val23;
    logic [1:0]                greedy;
    logic                      explore;
    logic                      capture;

    logic       ep_over;
    logic [7:0] episode_inc;
    logic [8:0] eps_diff;
    logic [7:0] eps_nx;

    assign lfsr_nx = {lfsr[14:0],
                      lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    // Strict compares keep ties on the lower index.
    always_comb begin
        idx01  = 2'd0;
        val01  = q0;
        idx23  = 2'd2;
        val23  = q2;
        greedy = 2'd0;
        if (q1 > q0) begin
            idx01 = 2'd1;
            val01 = q1;
        end
        if (q3 > q2) begin
            idx23 = 2'd3;
            val23 = q3;
        end
        greedy = (val23 > val01) ? idx23 : idx01;
    end

    // act is resolved at the capture edge so it is already
    // stable during SELECT, using that cycle's LFSR value.
    assign capture = (state == S_REQ) && q_valid;
    assign explore = lfsr_nx[7:0] < epsilon;

    assign ep_over = (state_in == GOAL) || (step_cnt == MAX_S);
    assign episode_inc = episode_cnt + 8'd1;

    assign eps_diff = {1'b0, epsilon} - {1'b0, EPS_DECAY};
    assign eps_nx = (eps_diff[8] || (eps_diff[7:0] < EPS_MIN))
                  ? EPS_MIN : eps_diff[7:0];

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     if (start) state_nx = S_REQ;
            S_REQ:      if (q_valid) state_nx = S_SELECT;
            S_SELECT:   state_nx = S_SETTLE;
            S_SETTLE:   state_nx = S_CHECK;
            S_CHECK:    state_nx = ep_over ? S_END : S_REQ;
            S_END:      state_nx = (episode_inc == MAX_E)
                                 ? S_DONE : S_SETTLE_R;
            S_SETTLE_R: state_nx = S_REQ;
            S_DONE:     state_nx = S_DONE;
            default:    state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            lfsr             <= SEED;
            act              <= 2'd0;
            act_valid        <= 1'b0;
            change_iteration <= 1'b0;
            q_req            <= 1'b0;
            step_cnt         <= 8'd0;
            episode_cnt      <= 8'd0;
            epsilon          <= EPS_INIT;
            done             <= 1'b0;
        end else begin
            state            <= state_nx;
            lfsr             <= lfsr_nx;
            act_valid        <= capture;
            change_iteration <= (state == S_CHECK) && ep_over;
            q_req            <= (state_nx == S_REQ);
            done             <= (state_nx == S_DONE);
            if (capture) begin
                act <= explore ? lfsr_nx[9:8] : greedy;
            end
            if (state == S_SELECT) begin
                step_cnt <= step_cnt + 8'd1;
            end
            if (state == S_END) begin
                step_cnt    <= 8'd0;
                episode_cnt <= episode_inc;
                epsilon     <= eps_nx;
            end
        end
    end

endmodule

// File: tb/tb_action_selector.sv
// Directed bench for action_selector: greedy table, explore
// against an LFSR model, goal, step limit, done and reset.
module tb_action_selector;

    typedef struct {
        logic signed [15:0] q [4];
        logic [1:0]         exp_act;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_i     [4];
    logic               start_i   [4];
    logic               q_valid_i [4];
    logic [4:0]         state_i   [4];
    logic signed [15:0] q0_i [4];
    logic signed [15:0] q1_i [4];
    logic signed [15:0] q2_i [4];
    logic signed [15:0] q3_i [4];

    logic       q_req_o [4];
    logic [1:0] act_o   [4];
    logic       av_o    [4];
    logic       ci_o    [4];
    logic [7:0] step_o  [4];
    logic [7:0] ep_o    [4];
    logic [7:0] eps_o   [4];
    logic       done_o  [4];

    logic [15:0] lfsr_m [4];
    int checks = 0;
    int errors = 0;

    action_selector #(.EPS_INIT(8'd0), .EPS_MIN(8'd0)) u_greedy (
        .clk(clk), .rst(rst_i[0]), .start(start_i[0]),
        .state_in(state_i[0]), .q0(q0_i[0]), .q1(q1_i[0]),
        .q2(q2_i[0]), .q3(q3_i[0]), .q_valid(q_valid_i[0]),
        .q_req(q_req_o[0]), .act(act_o[0]), .act_valid(av_o[0]),
        .change_iteration(ci_o[0]), .step_cnt(step_o[0]),
        .episode_cnt(ep_o[0]), .epsilon(eps_o[0]),
        .done(done_o[0]));

    action_selector #(.EPS_INIT(8'd255)) u_explore (
        .clk(clk), .rst(rst_i[1]), .start(start_i[1]),
        .state_in(state_i[1]), .q0(q0_i[1]), .q1(q1_i[1]),
        .q2(q2_i[1]), .q3(q3_i[1]), .q_valid(q_valid_i[1]),
        .q_req(q_req_o[1]), .act(act_o[1]), .act_valid(av_o[1]),
        .change_iteration(ci_o[1]), .step_cnt(step_o[1]),
        .episode_cnt(ep_o[1]), .epsilon(eps_o[1]),
        .done(done_o[1]));

    action_selector #(.MAX_STEPS(4), .MAX_EPISODES(2),
                      .EPS_INIT(8'd14)) u_limit (
        .clk(clk), .rst(rst_i[2]), .start(start_i[2]),
        .state_in(state_i[2]), .q0(q0_i[2]), .q1(q1_i[2]),
        .q2(q2_i[2]), .q3(q3_i[2]), .q_valid(q_valid_i[2]),
        .q_req(q_req_o[2]), .act(act_o[2]), .act_valid(av_o[2]),
        .change_iteration(ci_o[2]), .step_cnt(step_o[2]),
        .episode_cnt(ep_o[2]), .epsilon(eps_o[2]),
        .done(done_o[2]));

    action_selector u_def (
        .clk(clk), .rst(rst_i[3]), .start(start_i[3]),
        .state_in(state_i[3]), .q0(q0_i[3]), .q1(q1_i[3]),
        .q2(q2_i[3]), .q3(q3_i[3]), .q_valid(q_valid_i[3]),
        .q_req(q_req_o[3]), .act(act_o[3]), .act_valid(av_o[3]),
        .change_iteration(ci_o[3]), .step_cnt(step_o[3]),
        .episode_cnt(ep_o[3]), .epsilon(eps_o[3]),
        .done(done_o[3]));

    // Reference LFSR: taps 16,14,13,11, shifting left.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst_i[k]) lfsr_m[k] <= 16'hACE1;
            else lfsr_m[k] <= {lfsr_m[k][14:0],
                lfsr_m[k][15] ^ lfsr_m[k][13] ^
                lfsr_m[k][12] ^ lfsr_m[k][10]};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got,
                       input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d",
                     name, got, exp);
        end
    endtask

    task automatic wait_req(input int k);
        bit seen = 0;
        for (int n = 0; n < 50 && !seen; n++) begin
            if (q_req_o[k]) seen = 1;
            else tick();
        end
        chk($sformatf("q_req_wait[%0d]", k), int'(seen), 1);
    endtask

    task automatic start_run(input int k);
        start_i[k] = 1'b1;
        tick();
        start_i[k] = 1'b0;
        chk($sformatf("start_q_req[%0d]", k), int'(q_req_o[k]), 1);
    endtask

    // Returns in the SETTLE cycle, two cycles after capture.
    task automatic do_step(input int k,
                           input logic signed [15:0] a,
                           input logic signed [15:0] b,
                           input logic signed [15:0] c,
                           input logic signed [15:0] d,
                           output logic [1:0] got,
                           output logic [15:0] lf);
        wait_req(k);
        q0_i[k] = a; q1_i[k] = b; q2_i[k] = c; q3_i[k] = d;
        q_valid_i[k] = 1'b1;
        tick();
        q_valid_i[k] = 1'b0;
        chk($sformatf("act_valid_hi[%0d]", k), int'(av_o[k]), 1);
        got = act_o[k];
        lf  = lfsr_m[k];
        tick();
        chk($sformatf("act_valid_lo[%0d]", k), int'(av_o[k]), 0);
    endtask

    vec_t vecs [8];
    logic [7:0] eps_rst [4];

    initial begin
        logic [1:0]  got;
        logic [15:0] lf;
        int          pulses;
        logic [1:0]  exp_a;

        vecs[0].q = '{16'sd5, -16'sd3, 16'sd12, 16'sd12};
        vecs[0].exp_act = 2'd2;
        vecs[1].q = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        vecs[1].exp_act = 2'd3;
        vecs[2].q = '{16'sd4, 16'sd3, 16'sd2, 16'sd1};
        vecs[2].exp_act = 2'd0;
        vecs[3].q = '{-16'sd5, -16'sd1, -16'sd7, -16'sd2};
        vecs[3].exp_act = 2'd1;
        vecs[4].q = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
        vecs[4].exp_act = 2'd0;
        vecs[5].q = '{-16'sd32768, -16'sd32768, -16'sd32768,
                      -16'sd32767};
        vecs[5].exp_act = 2'd3;
        vecs[6].q = '{16'sd32767, 16'sd32767, -16'sd1, 16'sd32767};
        vecs[6].exp_act = 2'd0;
        vecs[7].q = '{-16'sd1, 16'sd7, 16'sd7, -16'sd9};
        vecs[7].exp_act = 2'd1;
        eps_rst = '{8'd0, 8'd255, 8'd14, 8'd230};

        for (int k = 0; k < 4; k++) begin
            rst_i[k] = 1'b1; start_i[k] = 1'b0;
            q_valid_i[k] = 1'b0; state_i[k] = 5'd1;
            q0_i[k] = '0; q1_i[k] = '0; q2_i[k] = '0; q3_i[k] = '0;
        end
        tick();
        tick();
        for (int k = 0; k < 4; k++) rst_i[k] = 1'b0;

        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_act[%0d]", k), int'(act_o[k]), 0);
            chk($sformatf("rst_av[%0d]", k), int'(av_o[k]), 0);
            chk($sformatf("rst_ci[%0d]", k), int'(ci_o[k]), 0);
            chk($sformatf("rst_qreq[%0d]", k), int'(q_req_o[k]), 0);
            chk($sformatf("rst_step[%0d]", k), int'(step_o[k]), 0);
            chk($sformatf("rst_ep[%0d]", k), int'(ep_o[k]), 0);
            chk($sformatf("rst_eps[%0d]", k), int'(eps_o[k]),
                int'(eps_rst[k]));
            chk($sformatf("rst_done[%0d]", k), int'(done_o[k]), 0);
        end

        // Greedy table
        start_run(0);
        for (int i = 0; i < 8; i++) begin
            do_step(0, vecs[i].q[0], vecs[i].q[1], vecs[i].q[2],
                    vecs[i].q[3], got, lf);
            chk($sformatf("greedy_act[%0d]", i), int'(got),
                int'(vecs[i].exp_act));
            chk($sformatf("greedy_step[%0d]", i), int'(step_o[0]),
                i + 1);
        end

        // Explore with epsilon 255
        start_run(1);
        for (int i = 0; i < 12; i++) begin
            do_step(1, 16'sd0, 16'sd0, 16'sd0, 16'sd7, got, lf);
            exp_a = (lf[7:0] != 8'hFF) ? lf[9:8] : 2'd3;
            chk($sformatf("explore_act[%0d]", i), int'(got),
                int'(exp_a));
        end

        // Goal on the 3rd step
        state_i[3] = 5'd5;
        start_run(3);
        for (int s = 0; s < 3; s++) begin
            do_step(3, 16'sd1, 16'sd0, 16'sd0, 16'sd0, got, lf);
            if (s == 2) state_i[3] = 5'd25;
        end
        pulses = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (ci_o[3]) pulses++;
        end
        state_i[3] = 5'd1;
        chk("goal_ci_pulses", pulses, 1);
        chk("goal_step", int'(step_o[3]), 0);
        chk("goal_ep", int'(ep_o[3]), 1);
        chk("goal_eps", int'(eps_o[3]), 228);
        chk("goal_back_req", int'(q_req_o[3]), 1);

        // Step limit, epsilon floor, completion
        state_i[2] = 5'd3;
        start_run(2);
        for (int e = 0; e < 2; e++) begin
            for (int s = 0; s < 4; s++) begin
                do_step(2, 16'sd0, 16'sd9, 16'sd0, 16'sd0, got, lf);
                chk($sformatf("lim_step[%0d]", s), int'(step_o[2]),
                    s + 1);
            end
            chk("lim_ci_settle", int'(ci_o[2]), 0);
            tick();
            chk("lim_ci_check", int'(ci_o[2]), 0);
            tick();
            chk("lim_ci_end", int'(ci_o[2]), 1);
            tick();
            chk("lim_ci_after", int'(ci_o[2]), 0);
            chk("lim_eps", int'(eps_o[2]), 13);
            chk("lim_ep", int'(ep_o[2]), e + 1);
            chk("lim_step_clr", int'(step_o[2]), 0);
            chk("lim_done", int'(done_o[2]), e);
        end
        start_i[2] = 1'b1;
        for (int n = 0; n < 4; n++) tick();
        start_i[2] = 1'b0;
        tick();
        chk("done_hold", int'(done_o[2]), 1);
        chk("done_qreq", int'(q_req_o[2]), 0);
        chk("done_ep", int'(ep_o[2]), 2);

        // Second run with reset asserted in REQ
        rst_i[2] = 1'b1;
        tick();
        rst_i[2] = 1'b0;
        chk("rst_done_clr", int'(done_o[2]), 0);
        start_run(2);
        do_step(2, 16'sd0, 16'sd0, 16'sd5, 16'sd0, got, lf);
        wait_req(2);
        chk("pre_rst_step", int'(step_o[2]), 1);
        rst_i[2] = 1'b1;
        tick();
        rst_i[2] = 1'b0;
        chk("mid_rst_qreq", int'(q_req_o[2]), 0);
        chk("mid_rst_step", int'(step_o[2]), 0);
        chk("mid_rst_ep", int'(ep_o[2]), 0);
        chk("mid_rst_eps", int'(eps_o[2]), 14);
        chk("mid_rst_act", int'(act_o[2]), 0);
        tick();
        tick();
        chk("mid_rst_idle", int'(q_req_o[2]), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
